// File: rtl/taiko_pkg.sv
// Shared hit codes, field widths and entry packing for the drum hit recorder.
package taiko_pkg;

  localparam int unsigned STAMP_W = 8;
  localparam int unsigned ENTRY_W = 10;

  typedef enum logic [1:0] {
    HIT_NONE = 2'b00,
    HIT_DON  = 2'b01,
    HIT_KA   = 2'b10,
    HIT_BOTH = 2'b11
  } hit_code_e;

  function automatic logic [ENTRY_W-1:0] make_entry(input hit_code_e code,
                                                    input logic [STAMP_W-1:0] stamp);
    return {code, stamp};
  endfunction

endpackage

// File: rtl/hit_recorder_key_debounce.sv
// Per-key two-flop synchronizer, level debouncer and one-cycle press pulse.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 != r_level) begin
        // Accept the new level on the Nth consecutive differing cycle.
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
          r_press <= ~r_sync2;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/hit_recorder.sv
// Captures debounced drum presses with a beat timestamp into a show-ahead FIFO.
module hit_recorder
  import taiko_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DEPTH           = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               KEY_don,
  input  logic               KEY_ka,
  input  logic               started,
  input  logic [STAMP_W-1:0] counter160_4Hz,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_data,
  output logic [4:0]         count,
  input  logic               clear_ovf,
  output logic               overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic               w_press_don;
  logic               w_press_ka;
  logic               w_hit;
  hit_code_e          w_code;
  logic               w_full;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [4:0]         r_count;
  logic               r_ovf;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_don (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_key_n (KEY_don),
    .o_press (w_press_don)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ka (
    .i_clk   (CLOCK_50),
    .i_rst   (reset),
    .i_key_n (KEY_ka),
    .o_press (w_press_ka)
  );

  assign w_hit   = started & (w_press_don | w_press_ka);
  assign w_code  = hit_code_e'({w_press_ka, w_press_don});
  assign w_full  = (r_count == 5'(DEPTH));
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & out_ready;
  // A pop frees the slot the push lands in, so a full FIFO still accepts.
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  always_ff @(posedge CLOCK_50) begin
    if (w_push) r_mem[r_wr_ptr] <= make_entry(w_code, counter160_4Hz);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (clear_ovf) r_ovf <= 1'b0;
    end
  end

  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign count     = r_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_hit_recorder.sv
// Directed bench for hit_recorder with DEBOUNCE_CYCLES=4, DEPTH=16.
module tb_hit_recorder;

  logic       clk;
  logic       reset;
  logic       KEY_don;
  logic       KEY_ka;
  logic       started;
  logic [7:0] counter160_4Hz;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [4:0] count;
  logic       clear_ovf;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  hit_recorder #(.DEBOUNCE_CYCLES(4), .DEPTH(16)) dut (
    .CLOCK_50       (clk),
    .reset          (reset),
    .KEY_don        (KEY_don),
    .KEY_ka         (KEY_ka),
    .started        (started),
    .counter160_4Hz (counter160_4Hz),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .count          (count),
    .clear_ovf      (clear_ovf),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic don_hit(input logic [7:0] stamp);
    counter160_4Hz = stamp;
    KEY_don = 1'b0;
    cycles(12);
    KEY_don = 1'b1;
    cycles(12);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; KEY_don = 1'b1; KEY_ka = 1'b1; started = 1'b1;
    counter160_4Hz = 8'd0; out_ready = 1'b0; clear_ovf = 1'b0;
    cycles(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Scenario 1: single don press, latency boundary then entry content
    counter160_4Hz = 8'd37;
    KEY_don = 1'b0;
    cycles(6);
    check("s1_not_yet", 32'(count), 32'd0);
    cycles(1);
    check("s1_first_valid", 32'(out_valid), 32'd1);
    cycles(13);
    check("s1_count", 32'(count), 32'd1);
    check("s1_data", 32'(out_data), 32'h125);
    KEY_don = 1'b1;
    cycles(12);
    check("s1_release_ignored", 32'(count), 32'd1);
    check("s1_hold_data", 32'(out_data), 32'h125);
    pop_one();
    check("s1_popped", 32'(count), 32'd0);

    // Scenario 2: ka bounce then steady press
    counter160_4Hz = 8'd100;
    for (int i = 0; i < 3; i++) begin
      KEY_ka = 1'b0; cycles(2);
      KEY_ka = 1'b1; cycles(2);
    end
    check("s2_bounce_none", 32'(count), 32'd0);
    KEY_ka = 1'b0;
    cycles(20);
    check("s2_count", 32'(count), 32'd1);
    check("s2_data", 32'(out_data), 32'h264);
    KEY_ka = 1'b1;
    cycles(12);
    pop_one();

    // Scenario 3: both keys fall together
    counter160_4Hz = 8'd5;
    KEY_don = 1'b0; KEY_ka = 1'b0;
    cycles(20);
    check("s3_count", 32'(count), 32'd1);
    check("s3_data", 32'(out_data), 32'h305);
    KEY_don = 1'b1; KEY_ka = 1'b1;
    cycles(12);
    pop_one();
    check("s3_empty", 32'(count), 32'd0);

    // Scenario 4: 17 hits, no consumer
    for (int i = 0; i < 17; i++) don_hit(8'(10 + i));
    check("s4_count_full", 32'(count), 32'd16);
    check("s4_ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("s4_read%0d", i), 32'(out_data), 32'h100 | 32'(10 + i));
      pop_one();
    end
    check("s4_drained", 32'(out_valid), 32'd0);
    check("s4_ovf_sticky", 32'(overflow), 32'd1);
    clear_ovf = 1'b1;
    cycles(1);
    clear_ovf = 1'b0;
    check("s4_ovf_clear", 32'(overflow), 32'd0);

    // Scenario 5: push and pop together while full
    for (int i = 0; i < 16; i++) don_hit(8'(50 + i));
    check("s5_full", 32'(count), 32'd16);
    counter160_4Hz = 8'd99;
    KEY_don = 1'b0;
    cycles(6);
    out_ready = 1'b1;
    cycles(1);
    out_ready = 1'b0;
    check("s5_count_kept", 32'(count), 32'd16);
    check("s5_no_ovf", 32'(overflow), 32'd0);
    check("s5_new_head", 32'(out_data), 32'h133);
    KEY_don = 1'b1;
    cycles(12);
    for (int i = 0; i < 15; i++) pop_one();
    check("s5_tail_entry", 32'(out_data), 32'h163);
    pop_one();
    check("s5_empty", 32'(count), 32'd0);

    // Scenario 6: capture disabled, then reset with entries held
    started = 1'b0;
    for (int i = 0; i < 3; i++) don_hit(8'(20 + i));
    check("s6_disabled_count", 32'(count), 32'd0);
    check("s6_disabled_ovf", 32'(overflow), 32'd0);
    started = 1'b1;
    for (int i = 0; i < 5; i++) don_hit(8'(30 + i));
    check("s6_five", 32'(count), 32'd5);
    reset = 1'b1;
    KEY_don = 1'b0;
    counter160_4Hz = 8'd77;
    cycles(1);
    check("s6_rst_count", 32'(count), 32'd0);
    check("s6_rst_valid", 32'(out_valid), 32'd0);
    check("s6_rst_data", 32'(out_data), 32'd0);
    cycles(2);
    reset = 1'b0;
    cycles(20);
    check("s6_held_count", 32'(count), 32'd1);
    check("s6_held_data", 32'(out_data), 32'h14D);
    KEY_don = 1'b1;
    cycles(12);
    check("s6_held_once", 32'(count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hit_recorder.md
HIT_RECORDER -- requirements
Module: hit_recorder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000, is the number of stable cycles required to accept a key level change (5 ms at 50 MHz).
REQ-002 Parameter DEPTH, default 16, is the hit FIFO depth in entries, a power of two.
REQ-003 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 KEY_don  input  1  raw drum "don" button, active-low, asynchronous to CLOCK_50.
REQ-006 KEY_ka  input  1  raw drum "ka" button, active-low, asynchronous to CLOCK_50.
REQ-007 started  input  1  capture enable; hits are discarded while low.
REQ-008 counter160_4Hz  input  8  current beat timestamp, 0..159.
REQ-009 out_valid  output  1  FIFO head entry is available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_data  output  10  head entry {hit_code[9:8], stamp[7:0]}.
REQ-012 count  output  5  number of entries held, 0..DEPTH.
REQ-013 clear_ovf  input  1  clears the sticky overflow flag.
REQ-014 overflow  output  1  sticky flag: a hit was dropped because the FIFO was full.

Function
REQ-015 Each key SHALL pass through a two-flop synchronizer before debouncing.
REQ-016 The debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any interruption restarts the count.
REQ-017 A press event SHALL be a one-cycle pulse in the cycle after the debounced level goes 1->0; release events SHALL be ignored.
REQ-018 Hit code SHALL be 01 for don only, 10 for ka only, and 11 when both press events occur in the same cycle.
REQ-019 The stamp SHALL be counter160_4Hz sampled in the press-event cycle.
REQ-020 With started high, a press event SHALL push {code, stamp}, and the entry SHALL appear at out_data with out_valid high on the next cycle when the FIFO was empty.
REQ-021 out_data SHALL be show-ahead: the head entry is held stable while out_valid is high and out_ready is low.
REQ-022 A pop SHALL occur in a cycle only when out_valid and out_ready are both high.
REQ-023 A push and a pop in the same cycle SHALL both take effect, leaving count unchanged, including when the FIFO is full.
REQ-024 A push when full with no pop SHALL drop the entry and set overflow; stored entries are unaffected.
REQ-025 overflow SHALL clear on clear_ovf; when a drop and clear_ovf occur in the same cycle, set wins.
REQ-026 Press events while started is low SHALL be discarded and SHALL NOT set overflow.
REQ-027 Read and write pointers SHALL wrap modulo DEPTH; count SHALL saturate exactly at DEPTH, with full when count == DEPTH and out_valid == (count != 0).

Reset
REQ-028 Reset SHALL clear the synchronizers and debounced levels to 1 (released), debounce counters to 0, pointers to 0, count to 0, overflow to 0, out_valid to 0, and out_data to 0.
REQ-029 Reset asserted mid-debounce or with a non-empty FIFO SHALL discard all pending state; a key held low through reset release SHALL produce one press event after DEBOUNCE_CYCLES.

Structure
REQ-030 Package taiko_pkg SHALL hold HIT_DON=01, HIT_KA=10, HIT_BOTH=11, STAMP_W=8, and ENTRY_W=10.
REQ-031 Sub-module key_debounce (synchronizer, debounce counter, press pulse) SHALL be instantiated once per key; the FIFO SHALL be inline.

Verification (DEBOUNCE_CYCLES=4, DEPTH=16)
REQ-032 Scenario 1: KEY_don low 20 cycles with counter160_4Hz=37, started=1 -> exactly one entry 0x125 (code 01, stamp 37); count=1.
REQ-033 Scenario 2: KEY_ka bounces 0/1 every 2 cycles for 12 cycles, then stays low with counter160_4Hz=100 -> exactly one entry {10,100}=0x264.
REQ-034 Scenario 3: both keys fall in the same cycle with stamp 5 -> single entry 0x305; count=1.
REQ-035 Scenario 4: 17 hits with out_ready=0 -> count=16 and overflow=1; the first 16 stamps are read back in order; clear_ovf then sets overflow=0.
REQ-036 Scenario 5: FIFO full with out_ready=1 and a new hit pushed -> count stays 16 and overflow stays 0.
REQ-037 Scenario 6: started=0 with 3 hits -> count=0 and overflow=0; reset pulsed with 5 entries held -> count=0 and out_valid=0 on the next cycle.
